// File: rtl/cdb_broadcaster.sv
// Common-data-bus producer: per-FU result FIFOs, round-robin pick of one result per cycle,
// registered broadcast, and branch-tag squash of buffered results.

typedef struct packed {
  logic       sign;
  logic [3:0] tag;
} branch_tag_t;

typedef struct packed {
  logic        commit_valid;
  logic [2:0]  dest_ROB;
  logic [31:0] rd_v;
  logic        exception;
  logic        br_mispredict;
} CDB_output_t;

module cdb_broadcaster #(
  parameter int unsigned NUM_FU    = 4,
  parameter int unsigned ROB_WIDTH = 3,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  branch_tag_t                         flush_tag,
  input  logic        [NUM_FU-1:0]            fu_valid,
  input  logic        [NUM_FU-1:0][ROB_WIDTH-1:0] fu_dest_rob,
  input  logic        [NUM_FU-1:0][31:0]      fu_result,
  input  branch_tag_t [NUM_FU-1:0]            fu_br_tag,
  output logic        [NUM_FU-1:0]            fu_accept,
  output CDB_output_t                         cdb_out,
  output logic        [$clog2(NUM_FU)-1:0]    cdb_fu_id
);

  localparam int unsigned IdW  = $clog2(NUM_FU);
  localparam int unsigned PtrW = $clog2(BUF_DEPTH);
  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);

  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] dest;
    logic [31:0]          result;
    branch_tag_t          tag;
  } entry_t;

  entry_t          buf_q   [NUM_FU][BUF_DEPTH];
  logic [PtrW-1:0] head_q  [NUM_FU];
  logic [PtrW-1:0] tail_q  [NUM_FU];
  logic [CntW-1:0] count_q [NUM_FU];
  logic [IdW-1:0]  rr_q;

  logic [NUM_FU-1:0] req, silent, push, pop;
  logic              grant;
  logic [IdW-1:0]    winner, idx;

  // Same-sign tags: entry is younger than (descends from) the flushed branch.
  // Opposite sign: entry's tag set is contained in the flushed branch's set.
  function automatic logic is_killed(branch_tag_t t, branch_tag_t f);
    if (t.sign == f.sign) return (t.tag & f.tag) == f.tag;
    return (t.tag & f.tag) == t.tag;
  endfunction

  always_comb begin
    req    = '0;
    silent = '0;
    push   = '0;
    pop    = '0;
    grant  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      fu_accept[i] = (count_q[i] != CntW'(BUF_DEPTH));
      if (count_q[i] != '0 && !flush) begin
        if (buf_q[i][head_q[i]].valid) req[i] = 1'b1;
        else                           silent[i] = 1'b1;
      end
      push[i] = fu_valid[i] && fu_accept[i] && !(flush && is_killed(fu_br_tag[i], flush_tag));
    end
    // Scan from farthest to nearest so the nearest requester at/after rr_q wins.
    for (int unsigned k = NUM_FU; k > 0; k--) begin
      idx = IdW'((int'(rr_q) + int'(k) - 1) % NUM_FU);
      if (req[idx]) begin
        grant  = 1'b1;
        winner = idx;
      end
    end
    pop = silent;
    if (grant) pop[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        for (int unsigned d = 0; d < BUF_DEPTH; d++) buf_q[i][d] <= '0;
        head_q[i]  <= '0;
        tail_q[i]  <= '0;
        count_q[i] <= '0;
      end
      rr_q      <= '0;
      cdb_out   <= '0;
      cdb_fu_id <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        if (flush) begin
          for (int unsigned d = 0; d < BUF_DEPTH; d++) begin
            if (is_killed(buf_q[i][d].tag, flush_tag)) buf_q[i][d].valid <= 1'b0;
          end
        end
        // Tail slot is never occupied when push is allowed, so this cannot clash with the kill.
        if (push[i]) begin
          buf_q[i][tail_q[i]] <= '{valid: 1'b1, dest: fu_dest_rob[i], result: fu_result[i],
                                   tag: fu_br_tag[i]};
          tail_q[i] <= tail_q[i] + PtrW'(1);
        end
        if (pop[i]) head_q[i] <= head_q[i] + PtrW'(1);
        count_q[i] <= count_q[i] + CntW'(push[i]) - CntW'(pop[i]);
      end
      cdb_out.commit_valid <= grant;
      if (grant) begin
        cdb_out.dest_ROB <= buf_q[winner][head_q[winner]].dest;
        cdb_out.rd_v     <= buf_q[winner][head_q[winner]].result;
        cdb_fu_id        <= winner;
        rr_q             <= IdW'((int'(winner) + 1) % NUM_FU);
      end else begin
        cdb_fu_id <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed bench for cdb_broadcaster: reset, latency, round-robin order, backpressure, flush kill.

module tb_cdb_broadcaster;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [4:0]      flush_tag;
  logic [3:0]      fu_valid;
  logic [3:0][2:0] fu_dest_rob;
  logic [3:0][31:0] fu_result;
  logic [3:0][4:0] fu_br_tag;
  logic [3:0]      fu_accept;
  logic [37:0]     cdb_out;
  logic [1:0]      cdb_fu_id;

  int n_check = 0;
  int n_fail  = 0;

  cdb_broadcaster dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .flush_tag  (flush_tag),
    .fu_valid   (fu_valid),
    .fu_dest_rob(fu_dest_rob),
    .fu_result  (fu_result),
    .fu_br_tag  (fu_br_tag),
    .fu_accept  (fu_accept),
    .cdb_out    (cdb_out),
    .cdb_fu_id  (cdb_fu_id)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_check++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    fu_valid = '0;
    flush    = 1'b0;
  endtask

  task automatic set_fu(input int i, input logic [2:0] dest, input logic [31:0] res,
                        input logic [4:0] tag);
    fu_valid[i]    = 1'b1;
    fu_dest_rob[i] = dest;
    fu_result[i]   = res;
    fu_br_tag[i]   = tag;
  endtask

  task automatic expect_bcast(input string tag, input logic [1:0] fu, input logic [2:0] dest,
                              input logic [31:0] res);
    check_eq({tag, ".cv"}, 64'(cdb_out[37]), 64'd1);
    check_eq({tag, ".dest"}, 64'(cdb_out[36:34]), 64'(dest));
    check_eq({tag, ".rdv"}, 64'(cdb_out[33:2]), 64'(res));
    check_eq({tag, ".fu"}, 64'(cdb_fu_id), 64'(fu));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; flush_tag = '0; fu_valid = '0;
    fu_dest_rob = '0; fu_result = '0; fu_br_tag = '0;

    // 1: reset
    repeat (3) step();
    check_eq("rst.cv", 64'(cdb_out[37]), 64'd0);
    check_eq("rst.fu", 64'(cdb_fu_id), 64'd0);
    check_eq("rst.acc", 64'(fu_accept), 64'hf);
    rst = 1'b0;
    step();
    check_eq("post_rst.acc", 64'(fu_accept), 64'hf);

    // 2: single result latency
    set_fu(2, 3'd5, 32'hDEADBEEF, 5'b0_0000);
    step();
    clear_in();
    check_eq("lat.early_cv", 64'(cdb_out[37]), 64'd0);
    step();
    expect_bcast("lat", 2'd2, 3'd5, 32'hDEADBEEF);
    check_eq("lat.other", 64'(cdb_out[1:0]), 64'd0);
    step();
    check_eq("lat.idle_cv", 64'(cdb_out[37]), 64'd0);
    check_eq("lat.idle_fu", 64'(cdb_fu_id), 64'd0);

    // 1b: reset with non-empty FIFOs
    for (int i = 0; i < 4; i++) set_fu(i, 3'(i), 32'h100 + 32'(i), 5'b0);
    step();
    clear_in();
    rst = 1'b1;
    step();
    check_eq("rst_busy.cv", 64'(cdb_out[37]), 64'd0);
    rst = 1'b0;
    step();
    check_eq("rst_busy.cv1", 64'(cdb_out[37]), 64'd0);
    step();
    check_eq("rst_busy.cv2", 64'(cdb_out[37]), 64'd0);
    check_eq("rst_busy.acc", 64'(fu_accept), 64'hf);

    // 3: round-robin, back-to-back
    for (int i = 0; i < 4; i++) set_fu(i, 3'(i), 32'h200 + 32'(i), 5'b0);
    step();
    clear_in();
    for (int i = 0; i < 4; i++) begin
      step();
      expect_bcast($sformatf("rr%0d", i), 2'(i), 3'(i), 32'h200 + 32'(i));
    end
    set_fu(1, 3'd7, 32'h301, 5'b0);
    set_fu(0, 3'd6, 32'h300, 5'b0);
    step();
    clear_in();
    step();
    expect_bcast("rr_wrap0", 2'd0, 3'd6, 32'h300);
    step();
    expect_bcast("rr_wrap1", 2'd1, 3'd7, 32'h301);
    step();
    check_eq("rr.idle", 64'(cdb_out[37]), 64'd0);

    // 4: backpressure while a non-killing flush blocks grants
    flush = 1'b1; flush_tag = 5'b0_1111;
    set_fu(0, 3'd1, 32'h401, 5'b0_0000);
    step();
    check_eq("bp.acc1", 64'(fu_accept), 64'hf);
    set_fu(0, 3'd2, 32'h402, 5'b0_0000);
    step();
    check_eq("bp.acc2", 64'(fu_accept), 64'he);
    check_eq("bp.cv", 64'(cdb_out[37]), 64'd0);
    set_fu(0, 3'd3, 32'h403, 5'b0_0000);
    step();
    check_eq("bp.acc3", 64'(fu_accept), 64'he);
    clear_in();
    step();
    expect_bcast("bp.b1", 2'd0, 3'd1, 32'h401);
    check_eq("bp.acc_pop", 64'(fu_accept), 64'hf);
    step();
    expect_bcast("bp.b2", 2'd0, 3'd2, 32'h402);
    step();
    check_eq("bp.dropped", 64'(cdb_out[37]), 64'd0);

    // 5: flush kills buffered and incoming matching entries
    set_fu(0, 3'd4, 32'h500, 5'b0_0011);
    set_fu(1, 3'd5, 32'h501, 5'b0_0001);
    step();
    clear_in();
    flush = 1'b1; flush_tag = 5'b0_0011;
    set_fu(2, 3'd6, 32'h502, 5'b0_0111);
    step();
    check_eq("fl.cv", 64'(cdb_out[37]), 64'd0);
    clear_in();
    step();
    expect_bcast("fl.fu1", 2'd1, 3'd5, 32'h501);
    step();
    check_eq("fl.none", 64'(cdb_out[37]), 64'd0);
    check_eq("fl.acc", 64'(fu_accept), 64'hf);

    // 6: silent pop alongside a grant; rr moves past the winner
    set_fu(1, 3'd1, 32'h601, 5'b0_0011);
    set_fu(2, 3'd2, 32'h602, 5'b0_0001);
    step();
    clear_in();
    flush = 1'b1; flush_tag = 5'b0_0011;
    step();
    clear_in();
    set_fu(0, 3'd3, 32'h600, 5'b0);
    set_fu(3, 3'd7, 32'h603, 5'b0);
    step();
    clear_in();
    expect_bcast("sp.fu2", 2'd2, 3'd2, 32'h602);
    step();
    expect_bcast("sp.fu3", 2'd3, 3'd7, 32'h603);
    step();
    expect_bcast("sp.fu0", 2'd0, 3'd3, 32'h600);
    step();
    check_eq("sp.idle", 64'(cdb_out[37]), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_check, n_fail);
    $finish;
  end

endmodule
